// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, NUM_WR prioritised writes,
// optional write-to-read bypass, per-register busy scoreboard and write-collision flag.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_dat,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic [NUM_WR-1:0]          i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   i_wr_dat,
    input  logic                       i_claim_en,
    input  logic [ADDR_W-1:0]          i_claim_addr,
    output logic                       o_wr_collision,
    input  logic [ADDR_W-1:0]          i_debug_addr,
    output logic [DATA_W-1:0]          o_debug_data
);

    localparam int DEPTH = 1 << ADDR_W;

    if (NUM_RD < 1 || NUM_RD > 4 || NUM_WR < 1 || NUM_WR > 2) begin : g_bad_params
        $error("reg_file_mp: NUM_RD must be 1..4 and NUM_WR must be 1..2");
    end

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              collision_d;
    logic              collision_q;

    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [DATA_W-1:0] wr_dat  [NUM_WR];

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
        assign rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
    end

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
        assign wr_addr[j] = i_wr_addr[j*ADDR_W +: ADDR_W];
        assign wr_dat[j]  = i_wr_dat[j*DATA_W +: DATA_W];
    end

    always_comb begin
        collision_d = 1'b0;
        if (NUM_WR == 2) begin
            collision_d = i_wr_en[0] && i_wr_en[NUM_WR-1]
                       && (wr_addr[0] == wr_addr[NUM_WR-1]) && writable(wr_addr[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the register array is reset explicitly because software relies on
            // every register reading 0 after reset; this rules out a plain RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            collision_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates to the same element resolve to the last one
            // executed, so ascending port order gives the higher port priority.
            for (int j = 0; j < NUM_WR; j++) begin
                if (i_wr_en[j] && writable(wr_addr[j])) begin
                    regs[wr_addr[j]] <= wr_dat[j];
                    busy[wr_addr[j]] <= 1'b0;
                end
            end
            // A new claim supersedes a completing write to the same register.
            if (i_claim_en && writable(i_claim_addr)) begin
                busy[i_claim_addr] <= 1'b1;
            end
            collision_q <= collision_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        logic [DATA_W-1:0] dat;
        logic              bsy;

        // NOTE: both outputs get a default before any conditional override so the
        // process stays purely combinational with no inferred latch.
        always_comb begin
            dat = regs[rd_addr[k]];
            bsy = busy[rd_addr[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (i_wr_en[j] && wr_addr[j] == rd_addr[k]) begin
                        dat = wr_dat[j];
                        bsy = 1'b0;
                    end
                end
            end
            if (ZERO_REG != 0 && rd_addr[k] == '0) begin
                dat = '0;
                bsy = 1'b0;
            end
        end

        assign o_rd_dat[k*DATA_W +: DATA_W] = dat;
        assign o_rd_busy[k]                 = bsy;
    end

    assign o_wr_collision = collision_q;
    assign o_debug_data   = regs[i_debug_addr];

endmodule
